instr_prefetch_buffer: RTL and testbench
========================================

// Module: instr_prefetch_buffer
// PURPOSE
//  Fetch stage upstream of the decompressor/decoder. Generates sequential word addresses into imem,
//  buffers returned instructions with their PCs in a small FIFO, and hands them to the decoder over a
//  valid/ready handshake. Supports flush-and-redirect and a programmable stop address.
// PARAMETERS
//  WIDTH     32  data/address width in bits
//  DEPTH     4   FIFO entries; power of 2, >=2
//  RESET_PC  0   fetch PC loaded on reset
// PORTS
//  clk          in   1         clock; all state updates on rising edge
//  reset        in   1         asynchronous, active-high
//  start        in   1         IDLE->RUN pulse; ignored outside IDLE
//  end_pc       in   WIDTH     last address fetched before DRAIN; sampled every cycle
//  redirect     in   1         flush FIFO, restart fetch at redirect_pc
//  redirect_pc  in   WIDTH     new fetch PC; bits [1:0] forced to 0
//  imem_addr    out  WIDTH     fetch address (= fetch_pc)
//  imem_en      out  1         fetch issued this cycle
//  imem_rd      in   WIDTH     combinational imem read data for imem_addr
//  instr_out    out  WIDTH     instruction at FIFO head
//  instr_pc     out  WIDTH     PC of instr_out
//  instr_valid  out  1         head valid
//  instr_ready  in   1         decoder accepts head when valid&ready
//  count        out  $clog2(DEPTH)+1  occupied entries
//  busy         out  1         state != IDLE
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, fetch_pc=RESET_PC, FIFO empty, count=0, instr_valid=0,
//    imem_en=0, instr_out/instr_pc=0, busy=0.
//  - FSM: IDLE -start-> RUN; RUN -(fetch at fetch_pc==end_pc)-> DRAIN; DRAIN -(count==0, no pop-in)-> IDLE.
//    redirect in any state -> RUN next cycle (also from IDLE). redirect has priority over start/end_pc.
//  - Fetch: imem_en=1 iff state==RUN && !redirect && (count<DEPTH || pop this cycle). On fetch, push
//    {imem_rd, fetch_pc}; fetch_pc <= fetch_pc+4, wrapping modulo 2^WIDTH.
//  - Pop: instr_valid&&instr_ready. Push and pop same cycle at full or empty both legal; count unchanged.
//  - Latency: imem fetch at cycle N -> instr_valid at N+1 (no bypass). Throughput 1 word/cycle.
//  - redirect at cycle N: FIFO cleared and word fetched at N discarded; pop at N still completes;
//    fetch_pc<=redirect_pc&~3; instr_valid=0 at N+1; first new word valid at N+2.
//  - end_pc not 4-aligned or behind fetch_pc: fetch continues (with wrap) until equality is hit.
//  - Outputs when instr_valid=0 hold last head value (don't-care to consumers).
// CONFIGURATION
//  PREFETCH_BYPASS_EN defined: when FIFO empty and fetching, instr_out/instr_pc/instr_valid driven
//    combinationally from imem_rd/fetch_pc in the same cycle; if instr_ready, word is consumed and not
//    pushed. Latency 0. Redirect cycle never bypasses.
//  PREFETCH_BYPASS_EN undefined: outputs come only from FIFO head; latency 1.
// STRUCTURE
//  - prefetch_pkg: typedef enum logic [1:0] {PF_IDLE, PF_RUN, PF_DRAIN} pf_state_t;
//    localparam PC_STEP=4; typedef struct {data, pc} pf_entry_t (WIDTH-parameterised via module).
//  - Sub-module prefetch_fifo #(WIDTH,DEPTH): synchronous FIFO of {instr,pc}, push/pop/clear, count,
//    full/empty, async active-high reset. Top holds FSM, fetch_pc, bypass mux.
// TESTING
//  - Reset mid-RUN with 3 entries: all outputs 0, count=0, state IDLE, imem_addr=RESET_PC same cycle.
//  - start, end_pc=0x0C, ready=1, imem returns 0xA0+addr: decoder sees pc 0,4,8,C with instr
//    0xA0,0xA4,0xA8,0xAC on consecutive cycles, then busy drops after drain.
//  - ready=0, DEPTH=4: imem_en stops after 4 fetches, count=4; raise ready -> push+pop at full,
//    count stays 4, no word lost/duplicated.
//  - redirect to 0x103 at cycle with count=2: next cycle instr_valid=0, count=0; imem_addr=0x100;
//    following cycle head pc=0x100.
//  - fetch_pc=0xFFFFFFFC, end_pc=0x4: fetches 0xFFFFFFFC,0x0,0x4 in order, then DRAIN.
//  - Bypass build: empty FIFO, ready=1 -> instr_valid same cycle as imem_en, count stays 0;
//    non-bypass build same stimulus -> valid one cycle later.

Source files
------------

// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared FSM state type and fetch step for the instruction prefetch buffer
package prefetch_pkg;
    typedef enum logic [1:0] {PF_IDLE, PF_RUN, PF_DRAIN} pf_state_t;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO of {instr, pc} entries with push/pop/clear, async active-high reset
// Ports: push/pop/clear control, push_data/push_pc in, head_data/head_pc out, count/full/empty status.
// Push while full is accepted only with a simultaneous pop; clear empties the FIFO and wins over push/pop.
module prefetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         push_data,
    input  logic [WIDTH-1:0]         push_pc,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         head_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] pc;
    } pf_entry_t;
    pf_entry_t mem_q [DEPTH];
    pf_entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign head_data = mem_q[rd_q].data;
    assign head_pc = mem_q[rd_q].pc;
    assign count = cnt_q;
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = '{data: push_data, pc: push_pc};
        wr_d = clear ? '0 : wr_q + AW'(do_push);
        rd_d = clear ? '0 : rd_q + AW'(do_pop);
        cnt_d = clear ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential imem fetch into a small FIFO feeding the decoder over valid/ready
// Ports: start/end_pc/redirect/redirect_pc control; imem_addr/imem_en/imem_rd fetch interface;
// instr_out/instr_pc/instr_valid/instr_ready decoder handshake; count/busy status.
// Option macro PREFETCH_BYPASS_EN: an empty FIFO forwards imem_rd/fetch_pc to the decoder in the
// fetch cycle (latency 0); otherwise words leave only from the FIFO head (latency 1).
module instr_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       end_pc,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic [WIDTH-1:0]       imem_addr,
    output logic                   imem_en,
    input  logic [WIDTH-1:0]       imem_rd,
    output logic [WIDTH-1:0]       instr_out,
    output logic [WIDTH-1:0]       instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    pf_state_t state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, head_data, head_pc;
    logic fetch, bypass, fifo_push, fifo_pop, full, empty;
    // Pop is derived from the FIFO head only, so the fetch enable never loops through instr_valid.
    assign fifo_pop = !empty && instr_ready;
`ifdef PREFETCH_BYPASS_EN
    assign bypass = state_q == PF_RUN && !redirect && empty;
`else
    assign bypass = 1'b0;
`endif
    assign fetch = state_q == PF_RUN && !redirect && (!full || fifo_pop);
    // A bypassed word taken by the decoder this cycle must not also be queued.
    assign fifo_push = fetch && !(bypass && instr_ready);
    assign imem_en = fetch;
    assign imem_addr = fetch_pc_q;
    assign instr_valid = !empty || bypass;
    assign instr_out = bypass ? imem_rd : head_data;
    assign instr_pc = bypass ? fetch_pc_q : head_pc;
    assign busy = state_q != PF_IDLE;
    always_comb begin
        state_d = redirect                                          ? PF_RUN   :
                  (state_q == PF_IDLE && start)                     ? PF_RUN   :
                  (state_q == PF_RUN && fetch && fetch_pc_q == end_pc) ? PF_DRAIN :
                  (state_q == PF_DRAIN && empty)                    ? PF_IDLE  : state_q;
        fetch_pc_d = redirect ? (redirect_pc & ~WIDTH'(3)) :
                     fetch    ? fetch_pc_q + WIDTH'(PC_STEP) : fetch_pc_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PF_IDLE;
            fetch_pc_q <= WIDTH'(RESET_PC);
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end
    prefetch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(fifo_push),
        .pop(fifo_pop),
        .clear(redirect),
        .push_data(imem_rd),
        .push_pc(fetch_pc_q),
        .head_data(head_data),
        .head_pc(head_pc),
        .count(count),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: table-driven directed check of the prefetch buffer (default build)
module tb_instr_prefetch_buffer;
    logic clk = 0, reset = 1, start = 0, redirect = 0, instr_ready = 0;
    logic [31:0] end_pc = 0, redirect_pc = 0, imem_rd, imem_addr, instr_out, instr_pc;
    logic imem_en, instr_valid, busy;
    logic [2:0] count;
    int total = 0, bad = 0;

    instr_prefetch_buffer #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .end_pc(end_pc), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_en(imem_en), .imem_rd(imem_rd),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;
    // imem model: each word holds 0xA0 plus its own address
    assign imem_rd = imem_addr + 32'hA0;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic        rdy;
        logic        en;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
        logic [2:0]  cnt;
        logic        bsy;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic [31:0] epc, logic rdy,
                                logic en, logic [31:0] addr, logic vld, logic [31:0] ipc,
                                logic [2:0] cnt, logic bsy);
        mk = '{st, rd, rpc, epc, rdy, en, addr, vld, ipc, cnt, bsy};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // start, end_pc=0xC, ready=1
        vecs.push_back(mk(1,0,0,32'hC,1,   0,32'h0,0,0,0,0));
        vecs.push_back(mk(0,0,0,32'hC,1,   1,32'h0,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'hC,1,   1,32'h4,1,32'h0,1,1));
        vecs.push_back(mk(0,0,0,32'hC,1,   1,32'h8,1,32'h4,1,1));
        vecs.push_back(mk(0,0,0,32'hC,1,   1,32'hC,1,32'h8,1,1));
        vecs.push_back(mk(0,0,0,32'hC,1,   0,32'h10,1,32'hC,1,1));
        vecs.push_back(mk(0,0,0,32'hC,1,   0,32'h10,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'hC,1,   0,32'h10,0,0,0,0));
        // redirect from IDLE, ready=0 fills FIFO, then push+pop at full
        vecs.push_back(mk(0,1,32'h20,32'h1000,0, 0,32'h10,0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h1000,0,  1,32'h20,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,  1,32'h24,1,32'h20,1,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,  1,32'h28,1,32'h20,2,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,  1,32'h2C,1,32'h20,3,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,  0,32'h30,1,32'h20,4,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,  0,32'h30,1,32'h20,4,1));
        vecs.push_back(mk(0,0,0,32'h1000,1,  1,32'h30,1,32'h20,4,1));
        vecs.push_back(mk(0,0,0,32'h1000,1,  1,32'h34,1,32'h24,4,1));
        vecs.push_back(mk(0,0,0,32'h1000,1,  1,32'h38,1,32'h28,4,1));
        // redirect while full, then redirect to 0x103 with count=2
        vecs.push_back(mk(0,1,32'h40,32'h1000,0,  0,32'h3C,1,32'h2C,4,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,       1,32'h40,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,       1,32'h44,1,32'h40,1,1));
        vecs.push_back(mk(0,1,32'h103,32'h1000,0, 0,32'h48,1,32'h40,2,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,       1,32'h100,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'h1000,0,       1,32'h104,1,32'h100,1,1));
        // wrap: fetch 0xFFFFFFFC, 0x0, 0x4 then DRAIN
        vecs.push_back(mk(0,1,32'hFFFFFFFC,32'h4,1, 0,32'h108,1,32'h100,2,1));
        vecs.push_back(mk(0,0,0,32'h4,1,  1,32'hFFFFFFFC,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'h4,1,  1,32'h0,1,32'hFFFFFFFC,1,1));
        vecs.push_back(mk(0,0,0,32'h4,1,  1,32'h4,1,32'h0,1,1));
        vecs.push_back(mk(0,0,0,32'h4,1,  0,32'h8,1,32'h4,1,1));
        vecs.push_back(mk(0,0,0,32'h4,1,  0,32'h8,0,0,0,1));
        vecs.push_back(mk(0,0,0,32'h4,1,  0,32'h8,0,0,0,0));

        #1;
        chk("rst_en", 32'(imem_en), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        step;
        reset = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st;
            redirect = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            end_pc = vecs[i].epc;
            instr_ready = vecs[i].rdy;
            #4;
            chk($sformatf("v%0d_en", i), 32'(imem_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].ipc);
                chk($sformatf("v%0d_instr", i), instr_out, vecs[i].ipc + 32'hA0);
            end
            step;
        end

        // async reset mid-RUN with three entries queued
        start = 0;
        instr_ready = 0;
        end_pc = 32'h1000;
        redirect = 1;
        redirect_pc = 32'h200;
        step;
        redirect = 0;
        repeat (3) step;
        chk("mid_count", 32'(count), 3);
        chk("mid_busy", 32'(busy), 1);
        #2;
        reset = 1;
        #1;
        chk("mr_count", 32'(count), 0);
        chk("mr_valid", 32'(instr_valid), 0);
        chk("mr_en", 32'(imem_en), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_addr", imem_addr, 0);
        chk("mr_instr", instr_out, 0);
        chk("mr_pc", instr_pc, 0);
        step;
        reset = 0;
        step;
        chk("post_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
